pio_irq_in_multi: RTL and testbench



---
 rtl/pio_irq_in_multi.sv | 151 +++++++++++++++
 tb/tb_pio_irq_in_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_irq_in_multi.sv
// Multi-channel Avalon-MM input PIO: synchronised, debounced inputs with per-bit
// edge/level interrupt selection and write-1-to-clear edge capture.
module pio_irq_in_multi #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_POLARITY = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_ANY_EDGE = 3'd4;
    localparam logic [2:0] ADDR_LEVEL    = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;

    logic [WIDTH-1:0] polarity_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] any_edge_q;
    logic [WIDTH-1:0] level_mode_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] irq_src;
    logic [WIDTH-1:0] rdata_mux;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb = sync_val;
    end else begin : g_debounce
        localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q [WIDTH];
        logic [WIDTH-1:0] deb_q;

        // Toggle after DEBOUNCE_CYCLES consecutive mismatching cycles; any
        // agreement restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_q <= '0;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (sync_val[i] == deb_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] >= CNT_MAX) begin
                        deb_q[i] <= ~deb_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end

        assign deb = deb_q;
    end

    assign rise       = deb & ~deb_prev_q;
    assign fall       = ~deb & deb_prev_q;
    assign edge_evt   = (any_edge_q & (rise | fall)) |
                        (~any_edge_q & ((polarity_q & rise) | (~polarity_q & fall)));
    assign clear_mask = (wr_en && address == ADDR_CAPTURE) ? wdata : '0;
    assign irq_src    = (level_mode_q & ~(deb ^ polarity_q)) |
                        (~level_mode_q & edge_capture_q);

    always_comb begin
        rdata_mux = '0;
        case (address)
            ADDR_DATA:     rdata_mux = deb;
            ADDR_POLARITY: rdata_mux = polarity_q;
            ADDR_MASK:     rdata_mux = irq_mask_q;
            ADDR_CAPTURE:  rdata_mux = edge_capture_q;
            ADDR_ANY_EDGE: rdata_mux = any_edge_q;
            ADDR_LEVEL:    rdata_mux = level_mode_q;
            default:       rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q     <= '0;
            polarity_q     <= '0;
            irq_mask_q     <= RESET_MASK;
            edge_capture_q <= '0;
            any_edge_q     <= '0;
            level_mode_q   <= '0;
            readdata       <= '0;
            irq            <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            if (wr_en) begin
                case (address)
                    ADDR_POLARITY: polarity_q   <= wdata;
                    ADDR_MASK:     irq_mask_q   <= wdata;
                    ADDR_ANY_EDGE: any_edge_q   <= wdata;
                    ADDR_LEVEL:    level_mode_q <= wdata;
                    default:       ;
                endcase
            end
            // Event OR-ed after the clear so a coincident clear cannot drop it.
            edge_capture_q <= (edge_capture_q & ~clear_mask) | edge_evt;
            readdata       <= 32'(rdata_mux);
            irq            <= |(irq_src & irq_mask_q);
        end
    end

endmodule

// File: tb/tb_pio_irq_in_multi.sv
// Directed bench for pio_irq_in_multi: register table plus timed sequences for
// debounce, edge/level interrupts, coincident clear and mid-operation reset.
module tb_pio_irq_in_multi;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int checks;
    int errors;

    pio_irq_in_multi #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RESET_MASK     (8'h5A)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] got;

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        vecs[0]  = '{3'd1, 32'h0000_00A5, 32'h0000_00A5};
        vecs[1]  = '{3'd2, 32'hFFFF_FF3C, 32'h0000_003C};
        vecs[2]  = '{3'd4, 32'h0000_00FF, 32'h0000_00FF};
        vecs[3]  = '{3'd5, 32'h0000_000F, 32'h0000_000F};
        vecs[4]  = '{3'd6, 32'h0000_00FF, 32'h0000_0000};
        vecs[5]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{3'd0, 32'h0000_00FF, 32'h0000_0000};
        vecs[7]  = '{3'd1, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{3'd4, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{3'd5, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{3'd2, 32'h0000_0000, 32'h0000_0000};

        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        tick(3);
        reset_n = 1'b1;

        rd(3'd0, got); check("rst_data", got, 32'h00);
        rd(3'd1, got); check("rst_polarity", got, 32'h00);
        rd(3'd2, got); check("rst_mask", got, 32'h5A);
        rd(3'd3, got); check("rst_capture", got, 32'h00);
        rd(3'd4, got); check("rst_any_edge", got, 32'h00);
        rd(3'd5, got); check("rst_level", got, 32'h00);

        // Register write/readback table
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, got);
            check($sformatf("regvec%0d", i), got, vecs[i].exp);
        end
        tick(1);
        check("table_irq_idle", 32'(irq), 32'h0);

        // 1: falling edge capture, latency, W1C
        wr(3'd2, 32'h01);
        in_port[0] = 1'b1;
        tick(9);
        rd(3'd0, got); check("t1_data_high", got, 32'h01);
        rd(3'd3, got); check("t1_rise_ignored", got, 32'h00);
        in_port[0] = 1'b0;
        tick(7);
        check("t1_irq_before", 32'(irq), 32'h0);
        tick(1);
        check("t1_irq_latency", 32'(irq), 32'h1);
        rd(3'd3, got); check("t1_capture", got, 32'h01);
        wr(3'd3, 32'h01);
        check("t1_irq_at_clear", 32'(irq), 32'h1);
        tick(1);
        check("t1_irq_cleared", 32'(irq), 32'h0);
        rd(3'd3, got); check("t1_capture_cleared", got, 32'h00);

        // 2: glitch rejection and exact debounce boundary
        in_port[3] = 1'b1;
        tick(3);
        in_port[3] = 1'b0;
        tick(8);
        rd(3'd0, got); check("t2_glitch_data", got, 32'h00);
        rd(3'd3, got); check("t2_glitch_capture", got, 32'h00);
        in_port[3] = 1'b1;
        tick(5);
        rd(3'd0, got); check("t2_data_before", got, 32'h00);
        rd(3'd0, got); check("t2_data_after", got, 32'h08);
        in_port[3] = 1'b0;
        tick(8);
        rd(3'd3, got); check("t2_fall_capture", got, 32'h08);
        check("t2_masked_irq", 32'(irq), 32'h0);
        wr(3'd3, 32'hFF);
        rd(3'd3, got); check("t2_capture_cleared", got, 32'h00);

        // 3: any-edge, irq pulses on both edges
        wr(3'd4, 32'h04);
        wr(3'd2, 32'h04);
        in_port[2] = 1'b1;
        tick(8);
        check("t3_irq_rise", 32'(irq), 32'h1);
        rd(3'd3, got); check("t3_capture_rise", got, 32'h04);
        wr(3'd3, 32'h04);
        tick(1);
        check("t3_irq_clr1", 32'(irq), 32'h0);
        in_port[2] = 1'b0;
        tick(8);
        check("t3_irq_fall", 32'(irq), 32'h1);
        rd(3'd3, got); check("t3_capture_fall", got, 32'h04);
        wr(3'd3, 32'h04);
        tick(1);
        check("t3_irq_clr2", 32'(irq), 32'h0);
        wr(3'd4, 32'h00);

        // 4: level mode, active-high
        wr(3'd2, 32'h80);
        wr(3'd1, 32'h80);
        wr(3'd5, 32'h80);
        tick(1);
        check("t4_irq_idle", 32'(irq), 32'h0);
        in_port[7] = 1'b1;
        tick(8);
        check("t4_irq_level", 32'(irq), 32'h1);
        rd(3'd3, got); check("t4_capture_rise", got, 32'h80);
        wr(3'd3, 32'h80);
        tick(2);
        check("t4_irq_after_w1c", 32'(irq), 32'h1);
        rd(3'd3, got); check("t4_capture_cleared", got, 32'h00);
        wr(3'd2, 32'h00);
        check("t4_irq_at_unmask", 32'(irq), 32'h1);
        tick(1);
        check("t4_irq_unmasked", 32'(irq), 32'h0);
        wr(3'd2, 32'h80);
        tick(1);
        check("t4_irq_remask", 32'(irq), 32'h1);
        in_port[7] = 1'b0;
        tick(6);
        check("t4_irq_hold", 32'(irq), 32'h1);
        tick(1);
        check("t4_irq_drop", 32'(irq), 32'h0);
        rd(3'd3, got); check("t4_fall_ignored", got, 32'h00);
        wr(3'd5, 32'h00);
        wr(3'd1, 32'h00);

        // 5: W1C in the same cycle as a new event keeps the bit
        wr(3'd2, 32'h02);
        in_port[1] = 1'b1;
        tick(10);
        rd(3'd3, got); check("t5_rise_ignored", got, 32'h00);
        in_port[1] = 1'b0;
        tick(6);
        wr(3'd3, 32'h02);
        rd(3'd3, got); check("t5_simul_capture", got, 32'h02);
        check("t5_simul_irq", 32'(irq), 32'h1);
        wr(3'd3, 32'h02);
        tick(1);
        check("t5_irq_cleared", 32'(irq), 32'h0);

        // 6: reset mid-debounce, then re-acquire held inputs
        wr(3'd2, 32'hFF);
        wr(3'd1, 32'h30);
        wr(3'd5, 32'h10);
        in_port[4] = 1'b1;
        tick(8);
        check("t6_irq_pre", 32'(irq), 32'h1);
        in_port[5] = 1'b1;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_readdata", readdata, 32'h0);
        check("t6_rst_irq", 32'(irq), 32'h0);
        tick(2);
        reset_n = 1'b1;
        rd(3'd2, got); check("t6_mask", got, 32'h5A);
        rd(3'd1, got); check("t6_polarity", got, 32'h00);
        wr(3'd1, 32'h30);
        rd(3'd0, got); check("t6_data_early", got, 32'h00);
        tick(8);
        rd(3'd0, got); check("t6_data_reacq", got, 32'h30);
        rd(3'd3, got); check("t6_rise_event", got, 32'h30);
        check("t6_irq_post", 32'(irq), 32'h1);
        rd(3'd4, got); check("t6_any_edge", got, 32'h00);
        rd(3'd5, got); check("t6_level", got, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
